// File: rtl/seq_mag_comp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
package seq_mag_comp_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Number of 2-bit slices in a WIDTH-bit operand
  function automatic int unsigned slice_count(input int unsigned width);
    return width / 2;
  endfunction

  // Bits needed for the slice index; never narrower than one bit
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned n;
    n = width / 2;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_mag_comp_cmp2_slice.sv
// Combinational 2-bit unsigned comparator slice.
module cmp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  // Plain unsigned relation of the two slice values
  always_comb begin
    gt = (a > b);
    lt = (a < b);
    eq = (a == b);
  end

endmodule

// File: rtl/seq_mag_comp.sv
// Sequential magnitude comparator: walks one shared 2-bit slice from MSB to LSB,
// stopping on the first unequal slice.
module seq_mag_comp
  import seq_mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int unsigned NSLICE = slice_count(WIDTH);
  localparam int unsigned KW     = idx_width(WIDTH);
  localparam logic [KW-1:0] K_TOP = KW'(NSLICE - 1);

  state_e          state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
  logic [KW-1:0]   k_q, k_d;
  logic            gt_d, lt_d, eq_d, busy_d, done_d;
  logic [1:0]      sa, sb;
  logic            s_gt, s_lt, s_eq;
  logic            accept, last_slice, resolve;

  // A new compare may be accepted from IDLE or straight out of DONE
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign last_slice = (k_q == '0);
  assign resolve    = s_gt || s_lt || (s_eq && last_slice);

  // Slice mux: pick operand bits [2k+1:2k]
  always_comb begin
    sa = 2'b00;
    sb = 2'b00;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        sa = a_q[2*i +: 2];
        sb = b_q[2*i +: 2];
      end
    end
  end

  cmp2_slice u_slice (
    .a  (sa),
    .b  (sb),
    .gt (s_gt),
    .lt (s_lt),
    .eq (s_eq)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (resolve) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; results hold until the next accept
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    k_d    = k_q;
    gt_d   = gt;
    lt_d   = lt;
    eq_d   = eq;
    busy_d = (state_nxt == RUN);
    done_d = (state_nxt == DONE);
    if (accept) begin
      a_d  = a;
      b_d  = b;
      k_d  = K_TOP;
      gt_d = 1'b0;
      lt_d = 1'b0;
      eq_d = 1'b0;
    end else if (state == RUN) begin
      if (s_gt) begin
        gt_d = 1'b1;
      end else if (s_lt) begin
        lt_d = 1'b1;
      end else if (last_slice) begin
        eq_d = 1'b1;
      end else begin
        k_d = k_q - KW'(1);
      end
    end
  end

  // Operand, index, result and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      k_q  <= '0;
      gt   <= 1'b0;
      lt   <= 1'b0;
      eq   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      k_q  <= k_d;
      gt   <= gt_d;
      lt   <= lt_d;
      eq   <= eq_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Scoreboard bench for seq_mag_comp at WIDTH=8 and WIDTH=2.
module tb_seq_mag_comp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start2 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy8, done8, gt8, lt8, eq8;
  logic       busy2, done2, gt2, lt2, eq2;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  exp_t m8, m2;

  seq_mag_comp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .lt(lt8), .eq(eq8)
  );

  seq_mag_comp #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .gt(gt2), .lt(lt2), .eq(eq2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference result {gt, lt, eq} from plain unsigned comparison
  function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
    return {a > b, a < b, a == b};
  endfunction

  // Cycles to resolve: index (from MSB, 1-based) of first differing 2-bit pair
  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input int w);
    for (int n = 1; n <= w / 2; n++) begin
      if ((a >> (w - 2 * n)) != (b >> (w - 2 * n))) return n;
    end
    return w / 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one compare starting at the current negedge; returns at the negedge
  // of the DONE cycle plus gap idle cycles (gap=0 allows back-to-back)
  task automatic run(input int w, input logic [7:0] a, input logic [7:0] b,
                     input bit junk, input int gap);
    exp_t e;
    int   n;
    n = ref_lat(a, b, w);
    if (w == 8) begin
      start8 = 1'b1; a8 = a; b8 = b;
    end else begin
      start2 = 1'b1; a2 = a[1:0]; b2 = b[1:0];
    end
    @(posedge clk);
    @(negedge clk);
    e.res = ref_cmp(a, b);
    e.cyc = cyc + n;
    if (w == 8) q8.push_back(e);
    else        q2.push_back(e);
    check("busy_after_accept", 32'(w == 8 ? busy8 : busy2), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (junk && w == 8) begin
        start8 = 1'b1;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end else begin
        start8 = 1'b0;
        start2 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    start8 = 1'b0;
    start2 = 1'b0;
    repeat (gap) @(negedge clk);
    if (gap > 0) begin
      if (w == 8) check("held8", 32'({gt8, lt8, eq8}), 32'(ref_cmp(a, b)));
      else        check("held2", 32'({gt2, lt2, eq2}), 32'(ref_cmp(a, b)));
    end
  endtask

  // Monitors: pop and compare whenever a done pulse appears
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done8_spurious: done=1 with no pending compare (cycle %0d)", cyc);
      end else begin
        m8 = q8.pop_front();
        check("res8", 32'({gt8, lt8, eq8}), 32'(m8.res));
        check("lat8", 32'(cyc), 32'(m8.cyc));
        check("busy8_at_done", 32'(busy8), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done2_spurious: done=1 with no pending compare (cycle %0d)", cyc);
      end else begin
        m2 = q2.pop_front();
        check("res2", 32'({gt2, lt2, eq2}), 32'(m2.res));
        check("lat2", 32'(cyc), 32'(m2.cyc));
        check("busy2_at_done", 32'(busy2), 32'd0);
      end
    end
  end

  initial begin
    int         order[16];
    int         j, t;
    logic [7:0] ra, rb;

    repeat (2) @(negedge clk);
    check("reset8", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);
    check("reset2", 32'({busy2, done2, gt2, lt2, eq2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MSB slice decides
    run(8, 8'hA5, 8'h25, 1'b0, 2);

    // Reset in the middle of a running compare
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h3C;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_run", 32'({busy8, done8, gt8, lt8, eq8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full equality, held through IDLE
    run(8, 8'h3C, 8'h3C, 1'b0, 3);
    // Differ only in slice 0, with start and operands disturbed during RUN
    run(8, 8'h34, 8'h36, 1'b1, 2);
    // Back-to-back accept in the DONE cycle
    run(8, 8'h00, 8'hFF, 1'b0, 0);
    run(8, 8'hFF, 8'h00, 1'b0, 2);

    // Random sweep, biased toward long common prefixes
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ 8'(1 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run(8, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // WIDTH=2: directed, then all 16 pairs in shuffled order
    run(2, 8'd1, 8'd2, 1'b0, 1);
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 16; i++) begin
      run(2, 8'(order[i] >> 2), 8'(order[i] & 3), 1'b0, $urandom_range(0, 1));
    end

    repeat (4) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
